// File: rtl/pipelined_cpu.sv
// Five-stage in-order RV32 subset core with internal instruction/data memories and register file.
// Hazards are handled by EX-stage forwarding, one-cycle load-use stalls and ID-stage beq flushes.

module pipe_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (clr_i)     data_d = '0;
    else if (en_i) data_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;
endmodule

module pc_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o
);
  logic [31:0] pc_d, pc_q;

  always_comb pc_d = en_i ? pc_i : pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= 32'd0;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;
endmodule

// The write port exists for preloading; inside the core it is tied off.
module instr_mem (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] addr_i,
  output logic [31:0] instr_o
);
  logic [31:0] memory [0:255];
  logic        unused_addr;

  always_ff @(posedge clk_i) begin
    if (we_i) memory[waddr_i] <= wdata_i;
  end

  assign instr_o     = memory[addr_i[9:2]];
  assign unused_addr = ^{addr_i[31:10], addr_i[1:0]};
endmodule

module data_mem (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [31:0] memory [0:31];
  logic        unused_addr;

  always_ff @(posedge clk_i) begin
    if (we_i) memory[addr_i[6:2]] <= wdata_i;
  end

  assign rdata_o     = memory[addr_i[6:2]];
  assign unused_addr = ^{addr_i[31:7], addr_i[1:0]};
endmodule

module reg_file (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] register [0:31];
  logic        wr_en;

  assign wr_en = we_i && (waddr_i != 5'd0);

  always_ff @(posedge clk_i) begin
    if (wr_en) register[waddr_i] <= wdata_i;
  end

  // Write-through so an instruction three behind the writer sees the new value.
  always_comb begin
    rdata1_o = register[raddr1_i];
    rdata2_o = register[raddr2_i];
    if (wr_en && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (wr_en && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
    if (raddr1_i == 5'd0) rdata1_o = 32'd0;
    if (raddr2_i == 5'd0) rdata2_o = 32'd0;
  end
endmodule

module control_unit (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic       reg_write_o,
  output logic       mem_to_reg_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       alu_src_o,
  output logic       Branch_o,
  output logic [2:0] alu_op_o
);
  localparam logic [2:0] AluAdd = 3'd0, AluSub = 3'd1, AluAnd = 3'd2, AluXor = 3'd3;
  localparam logic [2:0] AluSll = 3'd4, AluSra = 3'd5, AluMul = 3'd6;

  always_comb begin
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    alu_src_o    = 1'b0;
    Branch_o     = 1'b0;
    alu_op_o     = AluAdd;
    case (opcode_i)
      7'b0110011: begin
        reg_write_o = 1'b1;
        case ({funct7_i, funct3_i})
          10'b0000000_111: alu_op_o = AluAnd;
          10'b0000000_100: alu_op_o = AluXor;
          10'b0000000_001: alu_op_o = AluSll;
          10'b0000000_000: alu_op_o = AluAdd;
          10'b0100000_000: alu_op_o = AluSub;
          10'b0000001_000: alu_op_o = AluMul;
          default:         reg_write_o = 1'b0;
        endcase
      end
      7'b0010011: begin
        if (funct3_i == 3'b000) begin
          reg_write_o = 1'b1;
          alu_src_o   = 1'b1;
        end else if (funct3_i == 3'b101) begin
          reg_write_o = 1'b1;
          alu_src_o   = 1'b1;
          alu_op_o    = AluSra;
        end
      end
      7'b0000011: begin
        if (funct3_i == 3'b010) begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          mem_read_o   = 1'b1;
          alu_src_o    = 1'b1;
        end
      end
      7'b0100011: begin
        if (funct3_i == 3'b010) begin
          mem_write_o = 1'b1;
          alu_src_o   = 1'b1;
        end
      end
      7'b1100011: Branch_o = (funct3_i == 3'b000);
      default: ;
    endcase
  end
endmodule

module hazard_unit (
  input  logic       idex_mem_read_i,
  input  logic [4:0] idex_rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  output logic       Stall_o
);
  assign Stall_o = idex_mem_read_i && ((idex_rd_i == rs1_i) || (idex_rd_i == rs2_i));
endmodule

module pipelined_cpu (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  localparam logic [2:0] AluAdd = 3'd0, AluSub = 3'd1, AluAnd = 3'd2, AluXor = 3'd3;
  localparam logic [2:0] AluSll = 3'd4, AluSra = 3'd5, AluMul = 3'd6;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [31:0] alu;
    logic [31:0] store;
    logic [4:0]  rd;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
  } memwb_t;

  ifid_t  ifid_d, ifid_r;
  idex_t  idex_d, idex_r;
  exmem_t exmem_d, exmem_r;
  memwb_t memwb_d, memwb_r;

  logic [31:0] pc, pc_next, if_instr, rd1, rd2, imm_b, branch_target;
  logic [31:0] fwd_a, fwd_b, op_b, alu_res, mem_rdata, wb_data;
  logic [4:0]  rs1, rs2;
  logic        stall, front_hold, branch, Flush;
  logic        c_reg_write, c_mem_to_reg, c_mem_read, c_mem_write, c_alu_src;
  logic [2:0]  c_alu_op;

  // IF
  pc_reg PC (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (~front_hold),
    .pc_i  (pc_next),
    .pc_o  (pc)
  );

  instr_mem Instruction_Memory (
    .clk_i   (clk_i),
    .we_i    (1'b0),
    .waddr_i (8'd0),
    .wdata_i (32'd0),
    .addr_i  (pc),
    .instr_o (if_instr)
  );

  // start_i=0 freezes the front end like a stall so nothing is re-issued.
  assign front_hold = stall || !start_i;
  assign pc_next    = Flush ? branch_target : pc + 32'd4;

  always_comb begin
    ifid_d       = '0;
    ifid_d.pc    = pc;
    ifid_d.instr = if_instr;
  end

  pipe_reg #(.Width($bits(ifid_t))) IFIDRegisters (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (~front_hold),
    .clr_i (Flush),
    .d_i   (ifid_d),
    .q_o   (ifid_r)
  );

  // ID
  assign rs1 = ifid_r.instr[19:15];
  assign rs2 = ifid_r.instr[24:20];

  reg_file Registers (
    .clk_i    (clk_i),
    .we_i     (memwb_r.reg_write && !rst_i),
    .waddr_i  (memwb_r.rd),
    .wdata_i  (wb_data),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  control_unit Control (
    .opcode_i     (ifid_r.instr[6:0]),
    .funct3_i     (ifid_r.instr[14:12]),
    .funct7_i     (ifid_r.instr[31:25]),
    .reg_write_o  (c_reg_write),
    .mem_to_reg_o (c_mem_to_reg),
    .mem_read_o   (c_mem_read),
    .mem_write_o  (c_mem_write),
    .alu_src_o    (c_alu_src),
    .Branch_o     (branch),
    .alu_op_o     (c_alu_op)
  );

  hazard_unit HazardDetectionUnit (
    .idex_mem_read_i (idex_r.mem_read),
    .idex_rd_i       (idex_r.rd),
    .rs1_i           (rs1),
    .rs2_i           (rs2),
    .Stall_o         (stall)
  );

  assign imm_b = {{19{ifid_r.instr[31]}}, ifid_r.instr[31], ifid_r.instr[7],
                  ifid_r.instr[30:25], ifid_r.instr[11:8], 1'b0};
  assign branch_target = ifid_r.pc + imm_b;
  assign Flush         = branch && (rd1 == rd2) && !front_hold;

  always_comb begin
    idex_d            = '0;
    idex_d.reg_write  = c_reg_write;
    idex_d.mem_to_reg = c_mem_to_reg;
    idex_d.mem_read   = c_mem_read;
    idex_d.mem_write  = c_mem_write;
    idex_d.alu_src    = c_alu_src;
    idex_d.alu_op     = c_alu_op;
    idex_d.rs1_data   = rd1;
    idex_d.rs2_data   = rd2;
    idex_d.rs1        = rs1;
    idex_d.rs2        = rs2;
    idex_d.rd         = ifid_r.instr[11:7];
    if (ifid_r.instr[6:0] == 7'b0100011) begin
      idex_d.imm = {{20{ifid_r.instr[31]}}, ifid_r.instr[31:25], ifid_r.instr[11:7]};
    end else begin
      idex_d.imm = {{20{ifid_r.instr[31]}}, ifid_r.instr[31:20]};
    end
  end

  pipe_reg #(.Width($bits(idex_t))) IDEXRegisters (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .clr_i (front_hold),
    .d_i   (idex_d),
    .q_o   (idex_r)
  );

  // EX
  always_comb begin
    fwd_a = idex_r.rs1_data;
    if (exmem_r.reg_write && (exmem_r.rd != 5'd0) && (exmem_r.rd == idex_r.rs1)) begin
      fwd_a = exmem_r.alu;
    end else if (memwb_r.reg_write && (memwb_r.rd != 5'd0) && (memwb_r.rd == idex_r.rs1)) begin
      fwd_a = wb_data;
    end
    fwd_b = idex_r.rs2_data;
    if (exmem_r.reg_write && (exmem_r.rd != 5'd0) && (exmem_r.rd == idex_r.rs2)) begin
      fwd_b = exmem_r.alu;
    end else if (memwb_r.reg_write && (memwb_r.rd != 5'd0) && (memwb_r.rd == idex_r.rs2)) begin
      fwd_b = wb_data;
    end
    op_b = idex_r.alu_src ? idex_r.imm : fwd_b;
    case (idex_r.alu_op)
      AluSub:  alu_res = fwd_a - op_b;
      AluAnd:  alu_res = fwd_a & op_b;
      AluXor:  alu_res = fwd_a ^ op_b;
      AluSll:  alu_res = fwd_a << op_b[4:0];
      AluSra:  alu_res = $unsigned($signed(fwd_a) >>> op_b[4:0]);
      AluMul:  alu_res = fwd_a * op_b;
      default: alu_res = fwd_a + op_b;
    endcase
  end

  always_comb begin
    exmem_d            = '0;
    exmem_d.reg_write  = idex_r.reg_write;
    exmem_d.mem_to_reg = idex_r.mem_to_reg;
    exmem_d.mem_write  = idex_r.mem_write;
    exmem_d.alu        = alu_res;
    exmem_d.store      = fwd_b;
    exmem_d.rd         = idex_r.rd;
  end

  pipe_reg #(.Width($bits(exmem_t))) EXMEMRegisters (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .clr_i (1'b0),
    .d_i   (exmem_d),
    .q_o   (exmem_r)
  );

  // MEM
  data_mem Data_Memory (
    .clk_i   (clk_i),
    .we_i    (exmem_r.mem_write && !rst_i),
    .addr_i  (exmem_r.alu),
    .wdata_i (exmem_r.store),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    memwb_d            = '0;
    memwb_d.reg_write  = exmem_r.reg_write;
    memwb_d.mem_to_reg = exmem_r.mem_to_reg;
    memwb_d.rdata      = mem_rdata;
    memwb_d.alu        = exmem_r.alu;
    memwb_d.rd         = exmem_r.rd;
  end

  pipe_reg #(.Width($bits(memwb_t))) MEMWBRegisters (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .clr_i (1'b0),
    .d_i   (memwb_d),
    .q_o   (memwb_r)
  );

  // WB
  assign wb_data = memwb_r.mem_to_reg ? memwb_r.rdata : memwb_r.alu;
endmodule

// File: tb/tb_pipelined_cpu.sv
// Bench for pipelined_cpu: directed vector table, hand-written hazard sequences and
// random programs checked against a sequential instruction-level model.

module tb_pipelined_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  always #5 clk = ~clk;

  pipelined_cpu dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int st_cnt, fl_cnt, hb_cnt;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  logic [31:0] m_reg [0:31];
  logic [31:0] m_mem [0:31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
  endfunction

  function automatic vec_t mk(input string name, input logic [31:0] instr, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.name  = name;
    v.instr = instr;
    v.a     = a;
    v.b     = b;
    v.exp   = exp;
    return v;
  endfunction

  // Instruction-level semantics of the register-writing operations.
  function automatic logic [31:0] ref_op(input int k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      0:       return a + b;
      1:       return a - b;
      2:       return a & b;
      3:       return a ^ b;
      4:       return a << b[4:0];
      5:       return a * b;
      6:       return a + b;
      7:       return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  task automatic begin_test();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] <= 32'h0;
    st_cnt = 0;
    fl_cnt = 0;
    hb_cnt = 0;
    #1;
  endtask

  task automatic start_run();
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    logic [31:0] held;
    bit          pend;
    pend = 1'b0;
    held = '0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (pend && (dut.PC.pc_o != held)) hb_cnt++;
      pend = 1'b0;
      if (dut.HazardDetectionUnit.Stall_o) begin
        st_cnt++;
        held = dut.PC.pc_o;
        pend = 1'b1;
      end
      if (dut.Flush) fl_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] w, a, b, imm;
    int          k, rd, r1, r2, idx, changed;

    // Reset state and free-running fetch of an all-zero program.
    begin_test();
    check("reset_pc", dut.PC.pc_o, 32'd0);
    check("reset_ifid", dut.IFIDRegisters.data_q[31:0], 32'd0);
    check("reset_idex_ctrl", {24'd0, dut.IDEXRegisters.data_q[$bits(dut.IDEXRegisters.data_q)-1 -: 8]},
          32'd0);
    dut.Registers.register[5] <= 32'h1234;
    start_run();
    for (int i = 1; i <= 4; i++) begin
      run_cycles(1);
      check($sformatf("pc_step%0d", i), dut.PC.pc_o, 32'(4 * i));
    end
    @(negedge clk);
    start = 1'b0;
    run_cycles(2);
    check("pc_hold_no_start", dut.PC.pc_o, 32'd16);
    check("nop_regs_kept", dut.Registers.register[5], 32'h1234);

    // Back-to-back ALU dependences, with register write timing.
    begin_test();
    dut.Registers.register[28] <= 32'd56;
    dut.Registers.register[1]  <= 32'hDEAD_BEEF;
    dut.Registers.register[2]  <= 32'hDEAD_BEEF;
    dut.Registers.register[3]  <= 32'hDEAD_BEEF;
    dut.Instruction_Memory.memory[0] <= enc_i(12'd10, 5'd0, 3'b000, 5'd1, 7'b0010011);
    dut.Instruction_Memory.memory[1] <= enc_r(7'b0000000, 5'd28, 5'd1, 3'b000, 5'd2);
    dut.Instruction_Memory.memory[2] <= enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd3);
    start_run();
    run_cycles(4);
    check("wb_not_before_edge5", dut.Registers.register[1], 32'hDEAD_BEEF);
    run_cycles(1);
    check("wb_at_edge5", dut.Registers.register[1], 32'd10);
    run_cycles(5);
    check("fwd_x2", dut.Registers.register[2], 32'd66);
    check("fwd_x3", dut.Registers.register[3], 32'd56);
    check("fwd_stalls", 32'(st_cnt), 32'd0);

    // Load-use stall.
    begin_test();
    dut.Data_Memory.memory[0] <= 32'd5;
    dut.Instruction_Memory.memory[0] <= enc_i(12'd0, 5'd0, 3'b010, 5'd4, 7'b0000011);
    dut.Instruction_Memory.memory[1] <= enc_r(7'b0000000, 5'd4, 5'd4, 3'b000, 5'd5);
    start_run();
    run_cycles(10);
    check("lu_stalls", 32'(st_cnt), 32'd1);
    check("lu_pc_held", 32'(hb_cnt), 32'd0);
    check("lu_x4", dut.Registers.register[4], 32'd5);
    check("lu_x5", dut.Registers.register[5], 32'd10);

    // Store then load of the same word.
    begin_test();
    dut.Registers.register[31] <= 32'd62;
    for (int i = 0; i < 32; i++) dut.Data_Memory.memory[i] <= 32'(100 + 3 * i);
    dut.Instruction_Memory.memory[0] <= enc_s(12'd20, 5'd31, 5'd0);
    dut.Instruction_Memory.memory[1] <= enc_i(12'd20, 5'd0, 3'b010, 5'd6, 7'b0000011);
    start_run();
    run_cycles(10);
    check("sw_dmem5", dut.Data_Memory.memory[5], 32'd62);
    changed = 0;
    for (int i = 0; i < 32; i++) begin
      if (i != 5 && dut.Data_Memory.memory[i] != 32'(100 + 3 * i)) changed++;
    end
    check("sw_others_changed", 32'(changed), 32'd0);
    check("sw_lw_x6", dut.Registers.register[6], 32'd62);

    // Taken and not-taken beq.
    for (int t = 0; t < 2; t++) begin
      begin_test();
      dut.Registers.register[24] <= 32'hFFFF_FFE8;
      dut.Registers.register[7]  <= 32'd0;
      dut.Registers.register[8]  <= 32'd0;
      dut.Instruction_Memory.memory[0] <= enc_b(13'd8, 5'd0, (t == 0) ? 5'd0 : 5'd24);
      dut.Instruction_Memory.memory[1] <= enc_i(12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011);
      dut.Instruction_Memory.memory[2] <= enc_i(12'd2, 5'd0, 3'b000, 5'd8, 7'b0010011);
      start_run();
      run_cycles(10);
      check($sformatf("beq%0d_flushes", t), 32'(fl_cnt), (t == 0) ? 32'd1 : 32'd0);
      check($sformatf("beq%0d_x7", t), dut.Registers.register[7], (t == 0) ? 32'd0 : 32'd1);
      check($sformatf("beq%0d_x8", t), dut.Registers.register[8], 32'd2);
    end

    // x0 is not writable, even through forwarding.
    begin_test();
    dut.Registers.register[0]  <= 32'd0;
    dut.Registers.register[28] <= 32'd56;
    dut.Instruction_Memory.memory[0] <= enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011);
    dut.Instruction_Memory.memory[1] <= enc_r(7'b0000000, 5'd28, 5'd0, 3'b000, 5'd12);
    start_run();
    run_cycles(10);
    check("x0_stays_zero", dut.Registers.register[0], 32'd0);
    check("x0_read_zero", dut.Registers.register[12], 32'd56);

    // Reset in mid-flight discards the in-flight instruction.
    begin_test();
    dut.Registers.register[11] <= 32'h77;
    dut.Instruction_Memory.memory[0] <= enc_i(12'd7, 5'd0, 3'b000, 5'd11, 7'b0010011);
    start_run();
    run_cycles(3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_pc", dut.PC.pc_o, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("midreset_x11", dut.Registers.register[11], 32'h77);

    // Single-instruction vector table: rd=x9, rs1=x24, rs2=x25.
    vq.push_back(mk("mul", enc_r(7'b0000001, 5'd25, 5'd24, 3'b000, 5'd9),
                    32'hFFFF_FFE8, 32'hFFFF_FFE7, 32'd600));
    vq.push_back(mk("srai1", enc_i(12'h401, 5'd24, 3'b101, 5'd9, 7'b0010011),
                    32'hFFFF_FFE6, 32'd0, 32'hFFFF_FFF3));
    vq.push_back(mk("srai31", enc_i(12'h41F, 5'd24, 3'b101, 5'd9, 7'b0010011),
                    32'h8000_0000, 32'd0, 32'hFFFF_FFFF));
    vq.push_back(mk("and", enc_r(7'b0000000, 5'd25, 5'd24, 3'b111, 5'd9),
                    32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200));
    vq.push_back(mk("xor", enc_r(7'b0000000, 5'd25, 5'd24, 3'b100, 5'd9),
                    32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F));
    vq.push_back(mk("sll", enc_r(7'b0000000, 5'd25, 5'd24, 3'b001, 5'd9),
                    32'd3, 32'h24, 32'h30));
    vq.push_back(mk("add_wrap", enc_r(7'b0000000, 5'd25, 5'd24, 3'b000, 5'd9),
                    32'hFFFF_FFFF, 32'd2, 32'd1));
    vq.push_back(mk("sub_neg", enc_r(7'b0100000, 5'd25, 5'd24, 3'b000, 5'd9),
                    32'd5, 32'd7, 32'hFFFF_FFFE));
    vq.push_back(mk("addi_neg", enc_i(12'hFFF, 5'd24, 3'b000, 5'd9, 7'b0010011),
                    32'd0, 32'd0, 32'hFFFF_FFFF));
    vq.push_back(mk("bad_opcode", enc_i(12'd5, 5'd24, 3'b000, 5'd9, 7'b1111111),
                    32'd1, 32'd2, 32'hA5A5_A5A5));
    vq.push_back(mk("bad_funct", enc_r(7'b0000000, 5'd25, 5'd24, 3'b010, 5'd9),
                    32'd1, 32'd2, 32'hA5A5_A5A5));
    foreach (vq[i]) begin
      begin_test();
      dut.Registers.register[24] <= vq[i].a;
      dut.Registers.register[25] <= vq[i].b;
      dut.Registers.register[9]  <= 32'hA5A5_A5A5;
      dut.Instruction_Memory.memory[0] <= vq[i].instr;
      start_run();
      run_cycles(8);
      check(vq[i].name, dut.Registers.register[9], vq[i].exp);
    end

    // Random dependent programs against a sequential model.
    for (int r = 0; r < 8; r++) begin
      begin_test();
      m_reg[0] = 32'd0;
      for (int i = 1; i < 8; i++) begin
        m_reg[i] = $urandom;
        dut.Registers.register[i] <= m_reg[i];
      end
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = $urandom;
        dut.Data_Memory.memory[i] <= m_mem[i];
      end
      for (int n = 0; n < 24; n++) begin
        k  = int'($urandom_range(0, 9));
        rd = int'($urandom_range(0, 7));
        r1 = int'($urandom_range(0, 7));
        r2 = int'($urandom_range(0, 7));
        a  = m_reg[r1];
        b  = m_reg[r2];
        w  = 32'd0;
        case (k)
          0: w = enc_r(7'b0000000, 5'(r2), 5'(r1), 3'b000, 5'(rd));
          1: w = enc_r(7'b0100000, 5'(r2), 5'(r1), 3'b000, 5'(rd));
          2: w = enc_r(7'b0000000, 5'(r2), 5'(r1), 3'b111, 5'(rd));
          3: w = enc_r(7'b0000000, 5'(r2), 5'(r1), 3'b100, 5'(rd));
          4: w = enc_r(7'b0000000, 5'(r2), 5'(r1), 3'b001, 5'(rd));
          5: w = enc_r(7'b0000001, 5'(r2), 5'(r1), 3'b000, 5'(rd));
          6: begin
            imm = 32'($signed($urandom_range(0, 4095) - 2048));
            b   = imm;
            w   = enc_i(imm[11:0], 5'(r1), 3'b000, 5'(rd), 7'b0010011);
          end
          7: begin
            b = 32'($urandom_range(0, 31));
            w = enc_i({7'b0100000, b[4:0]}, 5'(r1), 3'b101, 5'(rd), 7'b0010011);
          end
          8: begin
            idx = int'($urandom_range(0, 31));
            imm = 32'(idx * 4);
            w   = enc_i(imm[11:0], 5'd0, 3'b010, 5'(rd), 7'b0000011);
          end
          default: begin
            idx = int'($urandom_range(0, 31));
            imm = 32'(idx * 4);
            w   = enc_s(imm[11:0], 5'(r2), 5'd0);
          end
        endcase
        dut.Instruction_Memory.memory[n] <= w;
        if (k <= 7) begin
          if (rd != 0) m_reg[rd] = ref_op(k, a, b);
        end else if (k == 8) begin
          if (rd != 0) m_reg[rd] = m_mem[idx];
        end else begin
          m_mem[idx] = b;
        end
      end
      start_run();
      run_cycles(64);
      for (int i = 1; i < 8; i++) begin
        check($sformatf("rnd%0d_x%0d", r, i), dut.Registers.register[i], m_reg[i]);
      end
      for (int i = 0; i < 32; i++) begin
        check($sformatf("rnd%0d_mem%0d", r, i), dut.Data_Memory.memory[i], m_mem[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
